counter_ctrl: RTL and testbench
===============================

# counter_ctrl

Command sequencer that sits directly upstream of the up/down counter and drives its `load_n`, `data_load`, `up_down` and `ce` inputs. It accepts one command at a time over a valid/ready handshake: NOP, LOAD, count UP N steps or count DOWN N steps. It reads the counter's `max_count` and `zero_flag` back so it can stop early in saturating mode. It reports completion, saturation, abort and the executed step count to the testbench and system.

## Interface
- `WIDTH`, default 8: counter data width; must match the downstream counter.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: controller can accept a command; high only in IDLE.
- `cmd_op`  in  2: 00 NOP, 01 LOAD, 10 UP, 11 DOWN.
- `cmd_arg`  in  WIDTH: load value for LOAD, step count N for UP and DOWN.
- `cmd_sat`  in  1: saturating mode for UP and DOWN.
- `abort`  in  1: cancels a COUNT in progress.
- `load_n`  out  1: to counter, active-low load.
- `data_load`  out  WIDTH: to counter.
- `up_down`  out  1: to counter, 1 means up.
- `ce`  out  1: to counter, count enable.
- `max_count`  in  1: from counter.
- `zero_flag`  in  1: from counter.
- `busy`  out  1: state is not IDLE.
- `done`  out  1: one-cycle pulse when a command completes normally.
- `sat_hit`  out  1: one-cycle pulse, coincident with `done`, when a saturating stop occurred.
- `aborted`  out  1: one-cycle pulse when a command was aborted.
- `steps_done`  out  WIDTH: number of `ce` cycles issued for the current or last command.

## Operation
- **States:**
  - IDLE: `cmd_ready`=1.
  - LOAD: lasts exactly one cycle.
  - COUNT: lasts 1 to N cycles.
- **Accept:** a command is accepted on a rising edge where `cmd_valid` and `cmd_ready` are both high. On accept, `op`, `arg` and `sat` are registered and `steps_done` is cleared to 0.
- **Command decode:**
  - NOP goes to IDLE and pulses `done` next cycle.
  - LOAD goes to LOAD.
  - UP or DOWN with N=0 pulses `done` next cycle and issues no `ce`.
  - UP or DOWN with N>0 goes to COUNT, with `remaining` set to N.
- **LOAD state:** `load_n`=0 and `data_load`=arg_q for one cycle, then IDLE with `done`.
- **COUNT state:**
  - `up_down` = (op_q==UP).
  - `stop` = sat_q & (up ? `max_count` : `zero_flag`).
  - `ce` = !`stop` & !`abort`.
  - Each `ce` cycle decrements `remaining` and increments `steps_done`.
- **Leaving COUNT:**
  - When `ce` is issued with `remaining`==1: next state IDLE, pulse `done`.
  - When `stop`: next state IDLE, pulse `done` and `sat_hit`, no `ce` that cycle.
  - When `abort`: next state IDLE, pulse `aborted`, no `done`, no `ce`.
  - `abort` has priority over `stop`.
  - `abort` outside COUNT is ignored.
- **Non-saturating mode:** the counter wraps, 0xFF→0x00 up and 0x00→0xFF down. The controller does not check the flags in this mode.
- **Counter-side outputs** are combinational decodes of registered state. In IDLE: `load_n`=1, `ce`=0, `up_down`=0, `data_load`=0.
- **Reset:** asynchronous. State goes to IDLE and all counters are cleared.
  - Outputs after reset: `cmd_ready`=1, `busy`=0, `done`=0, `sat_hit`=0, `aborted`=0, `steps_done`=0, `load_n`=1, `ce`=0.
  - Reset mid-COUNT drops `ce` immediately and discards the command with no pulses.

## Timing
- Command accepted at edge k:
  - `busy` is high from cycle k+1.
  - LOAD drives `load_n`=0 in cycle k+1, and `done` and `cmd_ready` are high in cycle k+2.
  - COUNT N non-saturating: `ce` is high in cycles k+1..k+N, and `done` is in cycle k+N+1.
- Back-to-back throughput: the next command can be accepted at the edge ending the `done` cycle.
- `stop` is evaluated on the flags of the current `count_out`. The counter updates on the same edge that samples `ce`, so no overshoot occurs.
- `cmd_valid` while `busy` is held off by `cmd_ready`=0 and is not dropped.

## Structure
- Package `counter_ctrl_pkg`:
  - `cmd_op_e` enum: NOP, LOAD, UP, DOWN.
  - `ctrl_state_e` enum: IDLE, LOAD, COUNT.
- No sub-module; a single FSM plus the `remaining` and `steps_done` counters.
- Integration: connects to the counter through the shared `counter_if`. This block drives `load_n`, `data_load`, `up_down` and `ce`, and reads `max_count` and `zero_flag`.

## Test plan
All values assume WIDTH=8.
- LOAD arg 0x5A → `load_n`=0 with `data_load`=0x5A for one cycle. `done` follows, then counter `count_out`=0x5A.
- From 0x5A, UP N=3, sat=0 → `ce` high for 3 consecutive cycles with `up_down`=1. `count_out`=0x5D, `steps_done`=3, `done` pulses once.
- From 0xFC, UP N=10, sat=1 → 3 `ce` cycles to 0xFF, then stop. `sat_hit` and `done` pulse together, `steps_done`=3.
- From 0x02, DOWN N=5, sat=0 → `count_out` wraps to 0xFD, `steps_done`=5, `sat_hit`=0.
- UP N=100 with `abort` in the 3rd COUNT cycle → `ce` is low in the abort cycle. `aborted` pulses, `done`=0, `steps_done`=2, `cmd_ready`=1 next cycle.
- Two edge cases:
  - UP N=0 → `done` next cycle with no `ce`.
  - `rst_n` pulsed low mid-COUNT → `ce` drops asynchronously, `busy`=0, `steps_done`=0, no pulses.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter command sequencer: command opcodes and FSM states.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_COUNT = 2'b10
  } ctrl_state_e;

endpackage

// File: rtl/counter_ctrl_if.sv
// Command handshake into counter_ctrl: one command per valid/ready transfer.
interface counter_ctrl_if #(
  parameter int WIDTH = 8
);
  import counter_ctrl_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  cmd_op_e          cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic             cmd_sat;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, cmd_sat,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, cmd_sat,
    output cmd_ready
  );

endinterface

// File: rtl/counter_ctrl.sv
// Command sequencer driving an up/down counter's load_n/data_load/up_down/ce,
// with saturating early stop from the counter's max/zero flags and abort.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  counter_ctrl_if.slave    cmd,
  input  logic             abort,
  output logic             load_n,
  output logic [WIDTH-1:0] data_load,
  output logic             up_down,
  output logic             ce,
  input  logic             max_count,
  input  logic             zero_flag,
  output logic             busy,
  output logic             done,
  output logic             sat_hit,
  output logic             aborted,
  output logic [WIDTH-1:0] steps_done
);

  ctrl_state_e      state_q;
  cmd_op_e          op_q;
  logic [WIDTH-1:0] arg_q;
  logic             sat_q;
  logic [WIDTH-1:0] remaining_q;
  logic [WIDTH-1:0] steps_q;
  logic             done_q;
  logic             sat_hit_q;
  logic             aborted_q;

  logic in_count;
  logic count_up;
  logic stop;

  assign in_count = (state_q == ST_COUNT);
  assign count_up = (op_q == OP_UP);
  // Flags reflect the counter value in this cycle, so stopping here never overshoots.
  assign stop     = sat_q & (count_up ? max_count : zero_flag);

  // Counter-side outputs decode the registered state so an async reset drops ce at once.
  assign load_n    = (state_q != ST_LOAD);
  assign data_load = (state_q == ST_LOAD) ? arg_q : '0;
  assign up_down   = in_count & count_up;
  assign ce        = in_count & ~stop & ~abort;

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign sat_hit       = sat_hit_q;
  assign aborted       = aborted_q;
  assign steps_done    = steps_q;

  // NOTE: every register here uses <= so all updates see the pre-edge values,
  // letting remaining_q==1 and the state change be decided from the same snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NOP;
      arg_q       <= '0;
      sat_q       <= 1'b0;
      remaining_q <= '0;
      steps_q     <= '0;
      done_q      <= 1'b0;
      sat_hit_q   <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      sat_hit_q <= 1'b0;
      aborted_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (cmd.cmd_valid) begin
            op_q    <= cmd.cmd_op;
            arg_q   <= cmd.cmd_arg;
            sat_q   <= cmd.cmd_sat;
            steps_q <= '0;
            case (cmd.cmd_op)
              OP_NOP:  done_q  <= 1'b1;
              OP_LOAD: state_q <= ST_LOAD;
              default: begin
                if (cmd.cmd_arg == '0) begin
                  done_q <= 1'b1;
                end else begin
                  state_q     <= ST_COUNT;
                  remaining_q <= cmd.cmd_arg;
                end
              end
            endcase
          end
        end

        ST_LOAD: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end

        ST_COUNT: begin
          if (abort) begin
            state_q   <= ST_IDLE;
            aborted_q <= 1'b1;
          end else if (stop) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b1;
            sat_hit_q <= 1'b1;
          end else begin
            remaining_q <= remaining_q - 1'b1;
            steps_q     <= steps_q + 1'b1;
            if (remaining_q == WIDTH'(1)) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl driving a behavioural 8-bit up/down counter.
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       abort;
  logic       load_n;
  logic [7:0] data_load;
  logic       up_down;
  logic       ce;
  logic       max_count;
  logic       zero_flag;
  logic       busy;
  logic       done;
  logic       sat_hit;
  logic       aborted;
  logic [7:0] steps_done;
  logic [7:0] count_out;

  int checks = 0;
  int errors = 0;

  counter_ctrl_if #(.WIDTH(8)) cif ();

  counter_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cif),
    .abort      (abort),
    .load_n     (load_n),
    .data_load  (data_load),
    .up_down    (up_down),
    .ce         (ce),
    .max_count  (max_count),
    .zero_flag  (zero_flag),
    .busy       (busy),
    .done       (done),
    .sat_hit    (sat_hit),
    .aborted    (aborted),
    .steps_done (steps_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream counter model: wraps in both directions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       count_out <= 8'h00;
    else if (!load_n) count_out <= data_load;
    else if (ce)      count_out <= up_down ? count_out + 8'd1 : count_out - 8'd1;
  end
  assign max_count = (count_out == 8'hFF);
  assign zero_flag = (count_out == 8'h00);

  // Issue one command, then record outputs for ncyc cycles starting at k+1.
  task automatic run_cmd(input cmd_op_e op, input logic [7:0] arg, input logic sat,
                         input int ncyc, input int abort_at,
                         output logic [15:0] ce_v, output logic [15:0] up_v,
                         output logic [15:0] done_v, output logic [15:0] sat_v,
                         output logic [15:0] ab_v, output logic [15:0] rdy_v);
    ce_v = '0; up_v = '0; done_v = '0; sat_v = '0; ab_v = '0; rdy_v = '0;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_arg   = arg;
    cif.cmd_sat   = sat;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      if (i == abort_at) abort = 1'b1;
      @(negedge clk);
      ce_v[i]   = ce;
      up_v[i]   = up_down;
      done_v[i] = done;
      sat_v[i]  = sat_hit;
      ab_v[i]   = aborted;
      rdy_v[i]  = cif.cmd_ready;
      @(posedge clk); #1;
      abort = 1'b0;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({cif.cmd_ready, busy, done, sat_hit, aborted, load_n, ce} !== 7'b1000010) begin
      errors++;
      $display("FAIL reset_flags got %b want %b",
               {cif.cmd_ready, busy, done, sat_hit, aborted, load_n, ce}, 7'b1000010);
    end
    checks++;
    if (steps_done !== 8'h00) begin
      errors++;
      $display("FAIL reset_steps got %h want 00", steps_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    @(posedge clk); #1;
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = OP_LOAD;
    cif.cmd_arg   = 8'h5A;
    cif.cmd_sat   = 1'b0;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({load_n, data_load, busy, cif.cmd_ready, done} !== {1'b0, 8'h5A, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load_cycle got load_n=%b data=%h busy=%b rdy=%b done=%b want 0 5a 1 0 0",
               load_n, data_load, busy, cif.cmd_ready, done);
    end
    @(negedge clk);
    checks++;
    if ({load_n, data_load, done, cif.cmd_ready, busy} !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL load_done got load_n=%b data=%h done=%b rdy=%b busy=%b want 1 00 1 1 0",
               load_n, data_load, done, cif.cmd_ready, busy);
    end
    checks++;
    if (count_out !== 8'h5A) begin
      errors++;
      $display("FAIL load_count got %h want 5a", count_out);
    end
  endtask

  task automatic test_up_nosat();
    logic [15:0] ce_v, up_v, done_v, sat_v, ab_v, rdy_v;
    run_cmd(OP_UP, 8'd3, 1'b0, 5, -1, ce_v, up_v, done_v, sat_v, ab_v, rdy_v);
    checks++;
    if (ce_v !== 16'h0007) begin errors++; $display("FAIL up3_ce got %h want 0007", ce_v); end
    checks++;
    if (up_v !== 16'h0007) begin errors++; $display("FAIL up3_updown got %h want 0007", up_v); end
    checks++;
    if (done_v !== 16'h0008) begin errors++; $display("FAIL up3_done got %h want 0008", done_v); end
    checks++;
    if (sat_v !== 16'h0000) begin errors++; $display("FAIL up3_sat got %h want 0000", sat_v); end
    checks++;
    if ({count_out, steps_done} !== {8'h5D, 8'd3}) begin
      errors++;
      $display("FAIL up3_result got count=%h steps=%0d want 5d 3", count_out, steps_done);
    end
  endtask

  task automatic test_up_sat();
    logic [15:0] ce_v, up_v, done_v, sat_v, ab_v, rdy_v;
    run_cmd(OP_LOAD, 8'hFC, 1'b0, 2, -1, ce_v, up_v, done_v, sat_v, ab_v, rdy_v);
    run_cmd(OP_UP, 8'd10, 1'b1, 6, -1, ce_v, up_v, done_v, sat_v, ab_v, rdy_v);
    checks++;
    if (ce_v !== 16'h0007) begin errors++; $display("FAIL upsat_ce got %h want 0007", ce_v); end
    checks++;
    if (done_v !== 16'h0010) begin errors++; $display("FAIL upsat_done got %h want 0010", done_v); end
    checks++;
    if (sat_v !== 16'h0010) begin errors++; $display("FAIL upsat_hit got %h want 0010", sat_v); end
    checks++;
    if ({count_out, steps_done} !== {8'hFF, 8'd3}) begin
      errors++;
      $display("FAIL upsat_result got count=%h steps=%0d want ff 3", count_out, steps_done);
    end
  endtask

  task automatic test_down_wrap();
    logic [15:0] ce_v, up_v, done_v, sat_v, ab_v, rdy_v;
    run_cmd(OP_LOAD, 8'h02, 1'b0, 2, -1, ce_v, up_v, done_v, sat_v, ab_v, rdy_v);
    run_cmd(OP_DOWN, 8'd5, 1'b0, 7, -1, ce_v, up_v, done_v, sat_v, ab_v, rdy_v);
    checks++;
    if ({ce_v, up_v} !== {16'h001F, 16'h0000}) begin
      errors++;
      $display("FAIL down5_ce got ce=%h up=%h want 001f 0000", ce_v, up_v);
    end
    checks++;
    if ({done_v, sat_v} !== {16'h0020, 16'h0000}) begin
      errors++;
      $display("FAIL down5_done got done=%h sat=%h want 0020 0000", done_v, sat_v);
    end
    checks++;
    if ({count_out, steps_done} !== {8'hFD, 8'd5}) begin
      errors++;
      $display("FAIL down5_result got count=%h steps=%0d want fd 5", count_out, steps_done);
    end
  endtask

  task automatic test_abort();
    logic [15:0] ce_v, up_v, done_v, sat_v, ab_v, rdy_v;
    run_cmd(OP_UP, 8'd100, 1'b0, 5, 2, ce_v, up_v, done_v, sat_v, ab_v, rdy_v);
    checks++;
    if (ce_v !== 16'h0003) begin errors++; $display("FAIL abort_ce got %h want 0003", ce_v); end
    checks++;
    if (ab_v !== 16'h0008) begin errors++; $display("FAIL abort_pulse got %h want 0008", ab_v); end
    checks++;
    if (done_v !== 16'h0000) begin errors++; $display("FAIL abort_done got %h want 0000", done_v); end
    checks++;
    if (rdy_v !== 16'h0018) begin errors++; $display("FAIL abort_ready got %h want 0018", rdy_v); end
    checks++;
    if ({steps_done, count_out} !== {8'd2, 8'hFF}) begin
      errors++;
      $display("FAIL abort_result got steps=%0d count=%h want 2 ff", steps_done, count_out);
    end
  endtask

  task automatic test_zero_and_nop();
    logic [15:0] ce_v, up_v, done_v, sat_v, ab_v, rdy_v;
    run_cmd(OP_UP, 8'd0, 1'b0, 3, -1, ce_v, up_v, done_v, sat_v, ab_v, rdy_v);
    checks++;
    if ({ce_v, done_v, rdy_v} !== {16'h0000, 16'h0001, 16'h0007}) begin
      errors++;
      $display("FAIL up0 got ce=%h done=%h rdy=%h want 0000 0001 0007", ce_v, done_v, rdy_v);
    end
    checks++;
    if ({steps_done, count_out} !== {8'd0, 8'hFF}) begin
      errors++;
      $display("FAIL up0_result got steps=%0d count=%h want 0 ff", steps_done, count_out);
    end
    run_cmd(OP_NOP, 8'h77, 1'b1, 3, -1, ce_v, up_v, done_v, sat_v, ab_v, rdy_v);
    checks++;
    if ({ce_v, done_v, sat_v} !== {16'h0000, 16'h0001, 16'h0000}) begin
      errors++;
      $display("FAIL nop got ce=%h done=%h sat=%h want 0000 0001 0000", ce_v, done_v, sat_v);
    end
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if ({aborted, busy, ce} !== 3'b000) begin
      errors++;
      $display("FAIL idle_abort got aborted=%b busy=%b ce=%b want 000", aborted, busy, ce);
    end
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] ce_v, done_v, rdy_v;
    ce_v = '0; done_v = '0; rdy_v = '0;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = OP_LOAD;
    cif.cmd_arg   = 8'h33;
    cif.cmd_sat   = 1'b0;
    @(posedge clk); #1;
    cif.cmd_op  = OP_UP;
    cif.cmd_arg = 8'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ce_v[i]   = ce;
      done_v[i] = done;
      rdy_v[i]  = cif.cmd_ready;
      @(posedge clk); #1;
      if (i == 1) cif.cmd_valid = 1'b0;
    end
    checks++;
    if (ce_v !== 16'h000C) begin errors++; $display("FAIL b2b_ce got %h want 000c", ce_v); end
    checks++;
    if (done_v !== 16'h0012) begin errors++; $display("FAIL b2b_done got %h want 0012", done_v); end
    checks++;
    if (rdy_v !== 16'h0032) begin errors++; $display("FAIL b2b_ready got %h want 0032", rdy_v); end
    checks++;
    if ({count_out, steps_done} !== {8'h35, 8'd2}) begin
      errors++;
      $display("FAIL b2b_result got count=%h steps=%0d want 35 2", count_out, steps_done);
    end
  endtask

  task automatic test_reset_mid_count();
    logic pulse_seen;
    pulse_seen = 1'b0;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = OP_UP;
    cif.cmd_arg   = 8'd50;
    cif.cmd_sat   = 1'b0;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ce, busy, steps_done} !== {1'b1, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL rst_pre got ce=%b busy=%b steps=%0d want 1 1 1", ce, busy, steps_done);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ce, busy, steps_done, load_n} !== {1'b0, 1'b0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL rst_async got ce=%b busy=%b steps=%0d load_n=%b want 0 0 0 1",
               ce, busy, steps_done, load_n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || sat_hit || aborted || ce || busy) pulse_seen = 1'b1;
    end
    checks++;
    if (pulse_seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_after got activity=%b want 0", pulse_seen);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    abort         = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = OP_NOP;
    cif.cmd_arg   = 8'h00;
    cif.cmd_sat   = 1'b0;
    test_reset();
    test_load();
    test_up_nosat();
    test_up_sat();
    test_down_wrap();
    test_abort();
    test_zero_and_nop();
    test_back_to_back();
    test_reset_mid_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
